// File: rtl/axi_xfer_pkg.sv
// Shared definitions for the AXI read-to-BRAM loader: protocol limits,
// beat sizing and the transfer controller state encoding.
package axi_xfer_pkg;

  localparam int AXI_4K_BYTES  = 4096;
  localparam int AXI_MAX_BURST = 256;

  typedef enum logic {
    IDLE,
    RUN
  } xfer_state_e;

  // ceil(bytes / 2**bpb_log2) without the overflow risk of adding bpb-1 first
  function automatic logic [63:0] beats_from_bytes(input logic [63:0] bytes,
                                                   input int unsigned bpb_log2);
    logic [63:0] mask;
    mask = (64'd1 << bpb_log2) - 64'd1;
    return (bytes >> bpb_log2) + 64'(|(bytes & mask));
  endfunction

endpackage

// File: rtl/axi_axi2bram_if.sv
// AXI4 read-address and read-data channel subset used by the BRAM loader.
interface axi_axi2bram_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rdata, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axi_axis2bram.sv
// Stream-to-BRAM writer: every accepted beat becomes one registered BRAM
// write at the next contiguous word address.
module axi_axis2bram #(
  parameter int XS              = 32,
  parameter int BRAM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH      = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       beat_valid,
  input  logic [DATA_WIDTH-1:0]      beat_data,
  input  logic [XS-1:0]              total_beats,
  output logic                       final_beat,
  output logic                       wren,
  output logic [BRAM_ADDR_WIDTH-1:0] wraddr,
  output logic [DATA_WIDTH-1:0]      wrdata
);

  logic [XS-1:0] beat_idx;

  assign final_beat = beat_valid && (beat_idx == total_beats - XS'(1));

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; wrdata is a plain register, not a memory, so it is reset
  // to keep idle outputs at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_idx <= '0;
      wren     <= 1'b0;
      wraddr   <= '0;
      wrdata   <= '0;
    end else begin
      wren <= beat_valid;
      if (beat_valid) begin
        wraddr <= BRAM_ADDR_WIDTH'(beat_idx);
        wrdata <= beat_data;
      end
      if (clear)
        beat_idx <= '0;
      else if (beat_valid)
        beat_idx <= beat_idx + XS'(1);
    end
  end

endmodule

// File: rtl/axi_axi2bram.sv
// AXI4 read master that copies a contiguous byte region into a BRAM, issuing
// 4 KB-safe bursts with a bounded number in flight.
module axi_axi2bram
  import axi_xfer_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH      = 64,
  parameter int AXI_DATA_WIDTH      = 128,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = 128,
  parameter int MAX_BURST_LEN       = 64,
  parameter int MAX_OUTSTANDING     = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_a2b_start,
  output logic                           o_a2b_done,
  input  logic [AXI_ADDR_WIDTH-1:0]      i_a2b_data_addr,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_a2b_data_size_bytes,
  axi_axi2bram_if.master                 m_axi,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_a2b_wraddr,
  output logic [BRAM_DATA_WIDTH-1:0]     o_a2b_wrdata,
  output logic                           o_a2b_wren
);

  localparam int XS        = AXI_XFER_SIZE_WIDTH;
  localparam int BPB       = AXI_DATA_WIDTH / 8;
  localparam int BPB_LOG2  = $clog2(BPB);
  localparam int BURST_CAP = (MAX_BURST_LEN < AXI_MAX_BURST) ? MAX_BURST_LEN : AXI_MAX_BURST;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  xfer_state_e state, state_next;

  logic [AXI_ADDR_WIDTH-1:0] addr_q, cur_addr;
  logic [XS-1:0]             left_q, total_q, cur_left, start_beats, burst_len, page_beats;
  logic [CNT_W-1:0]          out_q;
  logic [12:0]               page_room;
  logic                      start_go, start_zero, issue, done_next;
  logic                      ar_hs, r_hs, rlast_hs, final_beat;

  assign start_beats = XS'(beats_from_bytes(64'(i_a2b_data_size_bytes), BPB_LOG2));
  assign start_go    = (state == IDLE) && i_a2b_start && (i_a2b_data_size_bytes != '0);
  assign start_zero  = (state == IDLE) && i_a2b_start && (i_a2b_data_size_bytes == '0);
  assign ar_hs       = m_axi.arvalid && m_axi.arready;
  assign r_hs        = m_axi.rvalid && m_axi.rready;
  assign rlast_hs    = r_hs && m_axi.rlast;
  assign m_axi.rready = (state == RUN);

  // The first burst is sized from the start inputs so arvalid rises the cycle
  // after start; later bursts come from the running address and beat count.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    cur_addr = addr_q;
    cur_left = left_q;
    issue    = 1'b0;
    if (state == IDLE) begin
      cur_addr = i_a2b_data_addr;
      cur_left = start_beats;
      issue    = start_go;
    end else begin
      issue = (!m_axi.arvalid || m_axi.arready) && (left_q != '0) &&
              (out_q < CNT_W'(MAX_OUTSTANDING));
    end
    page_room  = 13'(AXI_4K_BYTES) - {1'b0, cur_addr[11:0]};
    page_beats = XS'(page_room >> BPB_LOG2);
    burst_len  = cur_left;
    if (burst_len > XS'(BURST_CAP)) burst_len = XS'(BURST_CAP);
    if (burst_len > page_beats)     burst_len = page_beats;
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start_go) state_next = RUN;
        done_next = start_zero;
      end
      RUN: begin
        if (final_beat) state_next = IDLE;
        done_next = final_beat;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A burst counts as outstanding from the moment it is presented; since only
  // one burst is ever presented at a time this equals the handshaken count
  // seen at the next issue decision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axi.arvalid <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arlen   <= '0;
      addr_q        <= '0;
      left_q        <= '0;
      total_q       <= '0;
      out_q         <= '0;
      o_a2b_done    <= 1'b0;
    end else begin
      o_a2b_done <= done_next;
      if (start_go) total_q <= start_beats;
      if (issue) begin
        m_axi.arvalid <= 1'b1;
        m_axi.araddr  <= cur_addr;
        m_axi.arlen   <= 8'(burst_len - XS'(1));
        addr_q        <= cur_addr + (AXI_ADDR_WIDTH'(burst_len) << BPB_LOG2);
        left_q        <= cur_left - burst_len;
      end else if (ar_hs) begin
        m_axi.arvalid <= 1'b0;
      end
      if (start_go)
        out_q <= CNT_W'(1);
      else
        out_q <= out_q + CNT_W'(issue) - CNT_W'(rlast_hs);
    end
  end

  axi_axis2bram #(
    .XS              (XS),
    .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
    .DATA_WIDTH      (BRAM_DATA_WIDTH)
  ) u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_go),
    .beat_valid  (r_hs),
    .beat_data   (m_axi.rdata),
    .total_beats (total_q),
    .final_beat  (final_beat),
    .wren        (o_a2b_wren),
    .wraddr      (o_a2b_wraddr),
    .wrdata      (o_a2b_wrdata)
  );

endmodule
